// File: rtl/cam_pixel_capture.sv
// OV7670-style byte-pair capture -> RGB332, decimated and clipped, driving the frame RAM write port.
// Write strobe is registered one cycle after the second byte; no backpressure (the camera cannot be stalled).
module cam_pixel_capture #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15,
  parameter int VS_FILT       = 2,
  parameter int HREF_FILT     = 2,
  parameter int BYTE_ORDER    = 0,
  parameter int DECIM_X       = 1,
  parameter int DECIM_Y       = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_cam_data,
  input  logic [1:0]        i_mode,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [7:0]        o_w_data,
  output logic              o_w_en,
  output logic              o_frame_done,
  output logic [ADDR_W-1:0] o_line_count,
  output logic              o_clipped
);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, BYTE0, BYTE1} state_t;

  localparam logic [ADDR_W-1:0] LP_W     = ADDR_W'(SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] LP_H     = ADDR_W'(SCREEN_HEIGHT);
  localparam logic [7:0]        LP_VS    = 8'(VS_FILT);
  localparam logic [7:0]        LP_VS_M1 = 8'(VS_FILT - 1);
  localparam logic [7:0]        LP_HR_M1 = 8'(HREF_FILT - 1);
  localparam logic [1:0]        LP_DX_M1 = 2'(DECIM_X - 1);
  localparam logic [1:0]        LP_DY_M1 = 2'(DECIM_Y - 1);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_vs_cnt, r_lo_cnt, r_byte0;
  logic              r_href_seen, r_wrote;
  logic [ADDR_W-1:0] r_x, r_y;
  logic [1:0]        r_px_dec, r_ln_dec;
  logic              r_w_en, r_frame_done, r_clipped;
  logic [ADDR_W-1:0] r_w_addr;
  logic [7:0]        r_w_data;

  logic              w_frame_start, w_line_end, w_latch0, w_pixel, w_keep, w_in_range;
  logic [15:0]       w_pix16;
  logic [7:0]        w_rgb;
  logic [ADDR_W-1:0] w_addr;

  assign w_frame_start = i_vsync && (r_vs_cnt == LP_VS_M1);
  assign w_line_end    = !i_href && r_href_seen && (r_lo_cnt == LP_HR_M1);
  assign w_latch0      = i_href && ((r_state == WAIT_LINE) || (r_state == BYTE1));
  assign w_pixel       = i_href && (r_state == BYTE0);
  assign w_keep        = w_pixel && (r_px_dec == 2'd0) && (r_ln_dec == 2'd0);
  assign w_in_range    = (r_x < LP_W) && (r_y < LP_H);
  assign w_pix16       = (BYTE_ORDER != 0) ? {r_byte0, i_cam_data} : {i_cam_data, r_byte0};
  assign w_addr        = r_x + r_y * LP_W;

  always_comb begin
    w_rgb = 8'h00;
    case (i_mode)
      2'b00:   w_rgb = {w_pix16[15:13], w_pix16[10:8], w_pix16[4:3]};
      2'b01:   w_rgb = {w_pix16[15], 2'b00, w_pix16[10], 2'b00, w_pix16[4], 1'b0};
      2'b10:   w_rgb = {w_pix16[14:12], w_pix16[9:7], w_pix16[4:3]};
      default: w_rgb = w_pix16[7:0];
    endcase
  end

  // HREF high is only tracked once a frame is open, so lines before the first frame start never end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_cnt    <= 8'd0;
      r_lo_cnt    <= 8'd0;
      r_href_seen <= 1'b0;
    end else begin
      if (!i_vsync)
        r_vs_cnt <= 8'd0;
      else if (r_vs_cnt != LP_VS)
        r_vs_cnt <= r_vs_cnt + 8'd1;

      if (w_frame_start || w_line_end) begin
        r_href_seen <= 1'b0;
        r_lo_cnt    <= 8'd0;
      end else if (i_href) begin
        r_href_seen <= (r_state != IDLE);
        r_lo_cnt    <= 8'd0;
      end else if (r_href_seen) begin
        r_lo_cnt <= r_lo_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_frame_start) begin
      w_state_nxt = WAIT_LINE;
    end else begin
      case (r_state)
        IDLE:      w_state_nxt = IDLE;
        WAIT_LINE: if (i_href) w_state_nxt = BYTE0;
        BYTE0:     if (i_href) w_state_nxt = BYTE1;
                   else if (w_line_end) w_state_nxt = WAIT_LINE;
        BYTE1:     if (i_href) w_state_nxt = BYTE0;
                   else if (w_line_end) w_state_nxt = WAIT_LINE;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte0      <= 8'd0;
      r_x          <= '0;
      r_y          <= '0;
      r_px_dec     <= 2'd0;
      r_ln_dec     <= 2'd0;
      r_w_en       <= 1'b0;
      r_w_addr     <= '0;
      r_w_data     <= 8'd0;
      r_frame_done <= 1'b0;
      r_clipped    <= 1'b0;
      r_wrote      <= 1'b0;
    end else begin
      r_w_en       <= 1'b0;
      r_frame_done <= 1'b0;
      if (r_w_en) r_wrote <= 1'b1;

      if (w_frame_start) begin
        // A write strobe in flight this cycle still belongs to the frame being closed.
        r_frame_done <= r_wrote || r_w_en;
        r_wrote      <= 1'b0;
        r_x          <= '0;
        r_y          <= '0;
        r_px_dec     <= 2'd0;
        r_ln_dec     <= 2'd0;
        r_clipped    <= 1'b0;
      end else begin
        if (w_latch0) r_byte0 <= i_cam_data;

        if (w_pixel) r_px_dec <= (r_px_dec == LP_DX_M1) ? 2'd0 : r_px_dec + 2'd1;

        if (w_keep) begin
          if (w_in_range) begin
            r_w_en   <= 1'b1;
            r_w_addr <= w_addr;
            r_w_data <= w_rgb;
          end else begin
            r_clipped <= 1'b1;
          end
          if (r_x < LP_W) r_x <= r_x + 1'b1;
        end

        if (w_line_end) begin
          r_x      <= '0;
          r_px_dec <= 2'd0;
          r_ln_dec <= (r_ln_dec == LP_DY_M1) ? 2'd0 : r_ln_dec + 2'd1;
          if (r_ln_dec == 2'd0) begin
            if (r_y < LP_H) r_y <= r_y + 1'b1;
            else            r_clipped <= 1'b1;
          end
        end
      end
    end
  end

  assign o_w_en       = r_w_en;
  assign o_w_addr     = r_w_addr;
  assign o_w_data     = r_w_data;
  assign o_frame_done = r_frame_done;
  assign o_line_count = r_y;
  assign o_clipped    = r_clipped;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench: two capture instances (plain / decimated+swapped) on a shared camera bus, checked against
// a frame-geometry model that predicts every RAM write, frame-done pulse, line count and clip flag.
module tb_cam_pixel_capture;

  localparam int W = 16;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n, vsync, href;
  logic [7:0]  cam;
  logic [1:0]  mode;
  logic [14:0] w_addr_a, w_addr_b, lc_a, lc_b;
  logic [7:0]  w_data_a, w_data_b;
  logic        w_en_a, w_en_b, fd_a, fd_b, clip_a, clip_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_pixel_capture #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(15), .VS_FILT(2), .HREF_FILT(2),
                      .BYTE_ORDER(0), .DECIM_X(1), .DECIM_Y(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_href(href), .i_cam_data(cam), .i_mode(mode),
    .o_w_addr(w_addr_a), .o_w_data(w_data_a), .o_w_en(w_en_a), .o_frame_done(fd_a),
    .o_line_count(lc_a), .o_clipped(clip_a));

  cam_pixel_capture #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(15), .VS_FILT(2), .HREF_FILT(2),
                      .BYTE_ORDER(1), .DECIM_X(2), .DECIM_Y(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_href(href), .i_cam_data(cam), .i_mode(mode),
    .o_w_addr(w_addr_b), .o_w_data(w_data_b), .o_w_en(w_en_b), .o_frame_done(fd_b),
    .o_line_count(lc_b), .o_clipped(clip_b));

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int          dx [2] = '{1, 2};
  int          dy [2] = '{1, 2};
  bit          swap [2] = '{1'b0, 1'b1};
  logic [22:0] q0 [$];
  logic [22:0] q1 [$];
  bit          in_frame = 1'b0;
  int          line_idx = 0;
  int          writes [2];
  int          lines_st [2];
  bit          clip [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] conv(input logic [1:0] m, input logic [15:0] p);
    int pi, r, g, b, r5, g5;
    pi = int'({16'd0, p});
    r  = pi >> 11;
    g  = (pi >> 5) & 63;
    b  = pi & 31;
    r5 = (pi >> 10) & 31;
    g5 = (pi >> 5) & 31;
    case (m)
      2'd0:    return 8'((r >> 2) * 32 + (g >> 3) * 4 + (b >> 3));
      2'd1:    return 8'((r >> 4) * 128 + (g >> 5) * 16 + (b >> 4) * 2);
      2'd2:    return 8'((r5 >> 2) * 32 + (g5 >> 2) * 4 + (b >> 3));
      default: return 8'(pi & 255);
    endcase
  endfunction

  task automatic model_pixel(input int i, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] p;
    int row, col;
    for (int d = 0; d < 2; d++) begin
      p = swap[d] ? {b0, b1} : {b1, b0};
      if ((line_idx % dy[d] == 0) && (i % dx[d] == 0)) begin
        row = line_idx / dy[d];
        col = i / dx[d];
        if (row < H && col < W) begin
          if (d == 0) q0.push_back({15'(col + row * W), conv(mode, p)});
          else        q1.push_back({15'(col + row * W), conv(mode, p)});
          writes[d]++;
        end else begin
          clip[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_line_end();
    for (int d = 0; d < 2; d++)
      if (line_idx % dy[d] == 0) begin
        if (line_idx / dy[d] < H) lines_st[d]++;
        else                      clip[d] = 1'b1;
      end
    line_idx++;
  endtask

  task automatic model_clear();
    line_idx = 0;
    for (int d = 0; d < 2; d++) begin
      writes[d] = 0; lines_st[d] = 0; clip[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (w_en_a) begin
      chk("a_write_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) chk("a_write", 32'({w_addr_a, w_data_a}), 32'(q0.pop_front()));
    end
    if (w_en_b) begin
      chk("b_write_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) chk("b_write", 32'({w_addr_b, w_data_b}), 32'(q1.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b, input bit vs);
    href = 1'b1; cam = b; vsync = vs;
    tick();
    vsync = 1'b0;
  endtask

  task automatic check_zero_outputs();
    chk("rst_w_en", 32'({w_en_a, w_en_b}), 32'd0);
    chk("rst_fd", 32'({fd_a, fd_b}), 32'd0);
    chk("rst_clip", 32'({clip_a, clip_b}), 32'd0);
    chk("rst_addr_data", 32'({w_addr_a, w_data_a}) | 32'({w_addr_b, w_data_b}), 32'd0);
    chk("rst_line_count", 32'({lc_a, lc_b}), 32'd0);
  endtask

  task automatic reset_mid_line();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero_outputs();
    chk("rst_pending_a", 32'(q0.size()), 32'd0);
    chk("rst_pending_b", 32'(q1.size()), 32'd0);
    #1 rst_n = 1'b1;
    in_frame = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic send_line(input int npix, input bit odd, input int glitch_at, input int rst_at,
                           input bit fixed, input logic [15:0] fp);
    logic [7:0] b0, b1;
    for (int i = 0; i < npix; i++) begin
      if (i == rst_at) reset_mid_line();
      b0 = fixed ? fp[7:0]  : 8'($urandom);
      b1 = fixed ? fp[15:8] : 8'($urandom);
      if (i > 0 && $urandom_range(0, 5) == 0) begin href = 1'b0; cam = 8'($urandom); tick(); end
      drive(b0, i == glitch_at);
      if ($urandom_range(0, 5) == 0) begin href = 1'b0; cam = 8'($urandom); tick(); end
      drive(b1, 1'b0);
      if (in_frame) model_pixel(i, b0, b1);
    end
    if (odd) drive(8'($urandom), 1'b0);
    href = 1'b0;
    repeat (4) tick();
    if (in_frame) model_line_end();
  endtask

  task automatic frame_start();
    int fa, fb;
    bit efa, efb;
    chk("a_writes_drained", 32'(q0.size()), 32'd0);
    chk("b_writes_drained", 32'(q1.size()), 32'd0);
    chk("a_line_count", 32'(lc_a), 32'(lines_st[0]));
    chk("b_line_count", 32'(lc_b), 32'(lines_st[1]));
    chk("a_clipped", 32'(clip_a), 32'(clip[0]));
    chk("b_clipped", 32'(clip_b), 32'(clip[1]));
    efa = writes[0] > 0;
    efb = writes[1] > 0;
    fa = 0; fb = 0;
    vsync = 1'b1;
    repeat (4) begin
      @(negedge clk);
      fa += int'(fd_a);
      fb += int'(fd_b);
    end
    tick();
    vsync = 1'b0;
    chk("a_frame_done", 32'(fa), 32'(efa));
    chk("b_frame_done", 32'(fb), 32'(efb));
    in_frame = 1'b1;
    model_clear();
    chk("fs_clears_clip", 32'({clip_a, clip_b}), 32'd0);
    chk("fs_clears_lines", 32'({lc_a, lc_b}), 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; cam = 8'd0; mode = 2'd0;
    model_clear();
    #3 check_zero_outputs();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Lines before any frame start must be ignored
    send_line(6, 1'b0, -1, -1, 1'b0, 16'h0);
    mode = 2'd0;
    frame_start();

    // Full frame of magenta RGB565 sent low byte first
    for (int l = 0; l < H; l++) send_line(W, 1'b0, -1, -1, 1'b1, 16'hF81F);
    mode = 2'd1;
    frame_start();
    for (int l = 0; l < 3; l++) send_line(4, l == 1, -1, -1, 1'b1, 16'h8410);
    mode = 2'd3;
    frame_start();
    for (int l = 0; l < 3; l++) send_line(5, 1'b1, -1, -1, 1'b1, 16'h12AB);
    mode = 2'd0;
    frame_start();

    // One-cycle VSYNC glitch during pixel 5 must not restart the frame
    send_line(10, 1'b0, 5, -1, 1'b0, 16'h0);
    send_line(7, 1'b0, 3, -1, 1'b0, 16'h0);
    frame_start();

    // Overlong line clips; the following frame start clears the flag
    send_line(20, 1'b0, -1, -1, 1'b0, 16'h0);
    send_line(4, 1'b0, -1, -1, 1'b0, 16'h0);
    mode = 2'd2;
    frame_start();

    // Double-size input: exact fit for the decimating instance, clipping for the plain one
    for (int l = 0; l < 2 * H; l++) send_line(2 * W, 1'b0, -1, -1, 1'b0, 16'h0);
    mode = 2'd0;
    frame_start();

    // Reset during pixel 10 of line 3, then no writes until the next frame start
    for (int l = 0; l < 3; l++) send_line(12, 1'b0, -1, -1, 1'b0, 16'h0);
    send_line(12, 1'b0, -1, 10, 1'b0, 16'h0);
    send_line(12, 1'b0, -1, -1, 1'b0, 16'h0);
    frame_start();

    for (int f = 0; f < 4; f++) begin
      for (int l = 0; l < int'($urandom_range(1, 10)); l++)
        send_line(int'($urandom_range(1, 20)), 1'($urandom), -1, -1, 1'b0, 16'h0);
      mode = 2'($urandom);
      frame_start();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
